// File: rtl/button_debounce_multi_if.sv
// -----------------------------------------------------------------------------
// button_debounce_multi_if
//
// Groups the raw button inputs and the conditioned per-channel outputs of
// button_debounce_multi into one bundle.
//
//   btn_in      raw asynchronous button inputs, active-high (source -> conditioner)
//   btn_level   debounced level per channel
//   btn_press   one-cycle pulse on debounced rising edge (and auto-repeat pulses)
//   btn_release one-cycle pulse on debounced falling edge
//   btn_long    one-cycle pulse when a level has been held for the long-press time
//
// Modports:
//   master : the board/consumer side; drives btn_in, observes the outputs
//   slave  : the conditioner; samples btn_in, drives the outputs
// -----------------------------------------------------------------------------
interface button_debounce_multi_if #(
  parameter int unsigned N_CH = 4
) ();

  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;
  logic [N_CH-1:0] btn_long;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long
  );

endinterface

// File: rtl/button_debounce_multi.sv
// -----------------------------------------------------------------------------
// button_debounce_multi
//
// N-channel push-button conditioner. Every channel is fully independent: its
// own 2-FF synchroniser, debounce counter, long-press counter and (optionally)
// auto-repeat counter. Downstream logic consumes the one-cycle pulses directly.
//
// Parameters:
//   N_CH           number of button channels (>= 1)
//   DEBOUNCE_COUNT consecutive cycles of disagreement before the level flips
//   LONG_COUNT     cycles the level must stay high before btn_long fires
//   REPEAT_COUNT   auto-repeat period in cycles (only with AUTOREPEAT_EN)
//
// Ports:
//   clk     system clock
//   nrst    asynchronous active-low reset
//   btn_if  button_debounce_multi_if.slave: btn_in in, level/press/release/long out
//
// Build option:
//   AUTOREPEAT_EN  when defined, btn_press also pulses every REPEAT_COUNT cycles
//                  after btn_long while the button stays held. When undefined no
//                  repeat logic exists and btn_press only marks rising edges.
//
// Timing: if edge k first samples a new stable input, btn_level changes on edge
// k+DEBOUNCE_COUNT+1 (two synchroniser stages plus DEBOUNCE_COUNT count edges).
// -----------------------------------------------------------------------------
module button_debounce_multi #(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned DEBOUNCE_COUNT = 5_000_000,
  parameter int unsigned LONG_COUNT     = 100_000_000,
  parameter int unsigned REPEAT_COUNT   = 20_000_000
) (
  input  logic                   clk,
  input  logic                   nrst,
  button_debounce_multi_if.slave btn_if
);

  // Counter widths are sized to hold the terminal value itself.
  localparam int unsigned DbW = $clog2(DEBOUNCE_COUNT + 1);
  localparam int unsigned LgW = $clog2(LONG_COUNT + 1);

  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_COUNT - 1);
  localparam logic [LgW-1:0] LgLast = LgW'(LONG_COUNT - 1);
  localparam logic [LgW-1:0] LgMax  = LgW'(LONG_COUNT);

`ifdef AUTOREPEAT_EN
  localparam int unsigned    RpW    = $clog2(REPEAT_COUNT + 1);
  localparam logic [RpW-1:0] RpLast = RpW'(REPEAT_COUNT - 1);
`else
  // Repeat period is meaningless without the feature; fold it away explicitly.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^REPEAT_COUNT;
`endif

  logic [N_CH-1:0] level_vec;
  logic [N_CH-1:0] press_vec;
  logic [N_CH-1:0] release_vec;
  logic [N_CH-1:0] long_vec;

  for (genvar i = 0; i < N_CH; i++) begin : gen_ch

    // -------------------------------------------------------------------------
    // Synchroniser
    // -------------------------------------------------------------------------
    logic sync0_q;
    logic sync1_q;

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        sync0_q <= 1'b0;
        sync1_q <= 1'b0;
      end else begin
        sync0_q <= btn_if.btn_in[i];
        sync1_q <= sync0_q;
      end
    end

    // -------------------------------------------------------------------------
    // Debounce: count consecutive cycles where the synchronised input disagrees
    // with the current level; any agreement restarts the count.
    // -------------------------------------------------------------------------
    logic [DbW-1:0] db_cnt_q;
    logic [DbW-1:0] db_cnt_d;
    logic           level_q;
    logic           level_d;
    logic           db_done;

    always_comb begin
      db_cnt_d = db_cnt_q;
      level_d  = level_q;
      db_done  = 1'b0;
      if (sync1_q == level_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DbLast) begin
        db_cnt_d = '0;
        level_d  = sync1_q;
        db_done  = 1'b1;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end

    logic rise;
    logic fall;
    assign rise = db_done & sync1_q;
    assign fall = db_done & ~sync1_q;

    // -------------------------------------------------------------------------
    // Long press: counts cycles with level high, saturating at LONG_COUNT. The
    // pulse is tied to the single increment that reaches the terminal value, so
    // it can fire at most once per press.
    // -------------------------------------------------------------------------
    logic [LgW-1:0] lg_cnt_q;
    logic [LgW-1:0] lg_cnt_d;
    logic           long_d;

    always_comb begin
      lg_cnt_d = lg_cnt_q;
      long_d   = 1'b0;
      if (!level_q) begin
        lg_cnt_d = '0;
      end else if (lg_cnt_q != LgMax) begin
        lg_cnt_d = lg_cnt_q + LgW'(1);
        long_d   = (lg_cnt_q == LgLast);
      end
    end

    // -------------------------------------------------------------------------
    // Auto-repeat
    // -------------------------------------------------------------------------
    logic rp_fire;

`ifdef AUTOREPEAT_EN
    logic [RpW-1:0] rp_cnt_q;
    logic [RpW-1:0] rp_cnt_d;

    // Runs only once the long-press counter has saturated, i.e. from the cycle
    // after btn_long, so the first repeat lands REPEAT_COUNT cycles after it.
    always_comb begin
      rp_cnt_d = rp_cnt_q;
      rp_fire  = 1'b0;
      if (!level_q || (lg_cnt_q != LgMax)) begin
        rp_cnt_d = '0;
      end else if (rp_cnt_q == RpLast) begin
        rp_cnt_d = '0;
        // A repeat that lands on the debounced release is dropped so press and
        // release never coincide.
        rp_fire  = ~fall;
      end else begin
        rp_cnt_d = rp_cnt_q + RpW'(1);
      end
    end

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        rp_cnt_q <= '0;
      end else begin
        rp_cnt_q <= rp_cnt_d;
      end
    end
`else
    assign rp_fire = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Registered pulses: asserted in the same cycle btn_level shows the change.
    // -------------------------------------------------------------------------
    logic press_q;
    logic press_d;
    logic release_q;
    logic release_d;
    logic long_q;

    assign press_d   = rise | rp_fire;
    assign release_d = fall;

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        db_cnt_q  <= '0;
        level_q   <= 1'b0;
        lg_cnt_q  <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        db_cnt_q  <= db_cnt_d;
        level_q   <= level_d;
        lg_cnt_q  <= lg_cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
      end
    end

    assign level_vec[i]   = level_q;
    assign press_vec[i]   = press_q;
    assign release_vec[i] = release_q;
    assign long_vec[i]    = long_q;

  end : gen_ch

  assign btn_if.btn_level   = level_vec;
  assign btn_if.btn_press   = press_vec;
  assign btn_if.btn_release = release_vec;
  assign btn_if.btn_long    = long_vec;

endmodule

// File: tb/tb_button_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_button_debounce_multi
//
// Directed bench for button_debounce_multi with N_CH=2, DEBOUNCE_COUNT=4,
// LONG_COUNT=20, REPEAT_COUNT=8. Inputs change 1 time unit after a rising edge;
// outputs are read at the same point, after the edge has settled.
//
// Step numbering inside each scenario: the input is changed before step 1, and
// step s observes the outputs just after the s-th following clock edge. With
// this numbering a new stable level appears at step 6 (edge k+5 with k = 1).
// -----------------------------------------------------------------------------
module tb_button_debounce_multi;

  localparam int unsigned NCh = 2;

`ifdef AUTOREPEAT_EN
  localparam bit AutoRep = 1'b1;
`else
  localparam bit AutoRep = 1'b0;
`endif

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  button_debounce_multi_if #(.N_CH(NCh)) bus ();

  button_debounce_multi #(
    .N_CH          (NCh),
    .DEBOUNCE_COUNT(4),
    .LONG_COUNT    (20),
    .REPEAT_COUNT  (8)
  ) dut (
    .clk   (clk),
    .nrst  (nrst),
    .btn_if(bus)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {level, press, release, long}, 2 bits each.
  logic [7:0] obs;
  assign obs = {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    bus.btn_in = '0;
    nrst = 1'b0;
    step();
    step();
    nrst = 1'b1;
    step();
  endtask

  // Reset held with both buttons pressed, then released: both channels
  // debounce from scratch and press together at step 6.
  task automatic test_reset();
    logic [7:0] exp;
    nrst = 1'b0;
    bus.btn_in = 2'b11;
    for (int s = 1; s <= 3; s++) begin
      step();
      exp = 8'h00;
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL reset_hold step %0d: got %b want %b", s, obs, exp);
      end
    end
    nrst = 1'b1;
    for (int s = 1; s <= 9; s++) begin
      step();
      exp = {(s >= 6) ? 2'b11 : 2'b00, (s == 6) ? 2'b11 : 2'b00, 2'b00, 2'b00};
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL reset_release step %0d: got %b want %b", s, obs, exp);
      end
    end
  endtask

  // Reset asserted while ch0 is debounced high: outputs clear immediately,
  // and the still-held button is re-debounced from zero after release.
  task automatic test_reset_abort();
    logic [7:0] exp;
    reset_dut();
    bus.btn_in = 2'b01;
    repeat (10) step();
    nrst = 1'b0;
    #1;
    exp = 8'h00;
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL reset_async_clear: got %b want %b", obs, exp);
    end
    step();
    step();
    nrst = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      step();
      exp = {(s >= 6) ? 2'b01 : 2'b00, (s == 6) ? 2'b01 : 2'b00, 2'b00, 2'b00};
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL reset_abort_redebounce step %0d: got %b want %b", s, obs, exp);
      end
    end
  endtask

  // High input with a one-cycle low glitch every third cycle never reaches the
  // terminal count; a steady high afterwards debounces normally.
  task automatic test_glitch();
    logic [7:0] exp;
    reset_dut();
    for (int s = 0; s < 24; s++) begin
      bus.btn_in = (s % 3 == 2) ? 2'b00 : 2'b01;
      step();
      exp = 8'h00;
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL glitch_reject step %0d: got %b want %b", s, obs, exp);
      end
    end
    bus.btn_in = 2'b01;
    for (int s = 1; s <= 8; s++) begin
      step();
      exp = {(s >= 6) ? 2'b01 : 2'b00, (s == 6) ? 2'b01 : 2'b00, 2'b00, 2'b00};
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL glitch_then_steady step %0d: got %b want %b", s, obs, exp);
      end
    end
  endtask

  // Long hold: level at 6, btn_long at 26, input drops before step 37 so the
  // release lands at 42. With auto-repeat one extra press at 34; the repeat
  // due at 42 coincides with the release and must not appear.
  task automatic test_long_press();
    logic [7:0] exp;
    logic       pr;
    reset_dut();
    bus.btn_in = 2'b01;
    for (int s = 1; s <= 50; s++) begin
      if (s == 37) bus.btn_in = 2'b00;
      step();
      pr  = (s == 6) || (AutoRep && s == 34);
      exp = {1'b0, (s >= 6 && s < 42), 1'b0, pr, 1'b0, (s == 42), 1'b0, (s == 26)};
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL long_press step %0d: got %b want %b", s, obs, exp);
      end
    end
  endtask

  // Ten-cycle press: one press, one release, no long-press pulse.
  task automatic test_short_press();
    logic [7:0] exp;
    reset_dut();
    bus.btn_in = 2'b01;
    for (int s = 1; s <= 30; s++) begin
      if (s == 11) bus.btn_in = 2'b00;
      step();
      exp = {1'b0, (s >= 6 && s < 16), 1'b0, (s == 6), 1'b0, (s == 16), 2'b00};
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL short_press step %0d: got %b want %b", s, obs, exp);
      end
    end
  endtask

  // Input high for exactly DEBOUNCE_COUNT samples is just enough to flip the
  // level; it then falls back after another DEBOUNCE_COUNT cycles.
  task automatic test_min_pulse();
    logic [7:0] exp;
    reset_dut();
    bus.btn_in = 2'b01;
    for (int s = 1; s <= 14; s++) begin
      if (s == 5) bus.btn_in = 2'b00;
      step();
      exp = {1'b0, (s >= 6 && s < 10), 1'b0, (s == 6), 1'b0, (s == 10), 2'b00};
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL min_pulse step %0d: got %b want %b", s, obs, exp);
      end
    end
  endtask

  // Both pressed on the same edge; ch1 held for only three samples so it never
  // changes level while ch0 debounces exactly as if alone.
  task automatic test_independent();
    logic [7:0] exp;
    reset_dut();
    bus.btn_in = 2'b11;
    for (int s = 1; s <= 12; s++) begin
      if (s == 4) bus.btn_in = 2'b01;
      step();
      exp = {1'b0, (s >= 6), 1'b0, (s == 6), 2'b00, 2'b00};
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL independent step %0d: got %b want %b", s, obs, exp);
      end
    end
  endtask

  // Fifty-plus cycle hold: press at 6, long at 26, repeats at 34/42/50/58 only
  // with auto-repeat. Input drops before step 61; the repeat due at 66 would
  // coincide with the release and is dropped.
  task automatic test_autorepeat();
    logic [7:0] exp;
    logic       pr;
    reset_dut();
    bus.btn_in = 2'b01;
    for (int s = 1; s <= 72; s++) begin
      if (s == 61) bus.btn_in = 2'b00;
      step();
      pr  = (s == 6) || (AutoRep && (s == 34 || s == 42 || s == 50 || s == 58));
      exp = {1'b0, (s >= 6 && s < 66), 1'b0, pr, 1'b0, (s == 66), 1'b0, (s == 26)};
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL autorepeat step %0d: got %b want %b", s, obs, exp);
      end
    end
  endtask

  initial begin
    bus.btn_in = '0;
    test_reset();
    test_reset_abort();
    test_glitch();
    test_long_press();
    test_short_press();
    test_min_pulse();
    test_independent();
    test_autorepeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
